// File: rtl/demux_sched_pkg.sv
// Shared definitions for the round-robin demux scheduler: FSM states, default sizes and
// the one-hot to binary index helper.
package demux_sched_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam int unsigned N_DEF        = 8;
    localparam int unsigned MAX_HOLD_DEF = 16;

    // OR-combining the positions of set bits yields the exact index for a one-hot input
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/demux_rr_scheduler_rr_pick.sv
// Combinational rotate-priority picker: first set request scanning upward from ptr,
// wrapping N-1 -> 0.
module rr_pick #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             any
);

    int unsigned idx;
    logic        found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler driving a 1:8 demux select with a held one-hot grant.
// Optional grant watchdog built when DEMUX_SCHED_TIMEOUT_EN is defined.
module demux_rr_scheduler
    import demux_sched_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned IDX_W    = $clog2(N),
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [N-1:0]     i_req,
    input  logic             i_done,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_busy,
    output logic             o_timeout
);

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_idx, rot_ptr, pick_ptr;
    logic [N-1:0]     pick;
    logic             any;
    logic             new_grant;
    logic             expire;

    assign grant_idx = IDX_W'(onehot_to_idx(32'(grant_q)));
    assign rot_ptr   = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    // While granted, the picker already looks from the rotated pointer so a release regrants in the same edge
    assign pick_ptr  = (state_q == S_GRANT) ? rot_ptr : ptr_q;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (i_req),
        .ptr  (pick_ptr),
        .pick (pick),
        .any  (any)
    );

`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    logic [HOLD_W-1:0] hold_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || new_grant)      hold_q <= '0;
        else if (state_q == S_GRANT) hold_q <= hold_q + 1'b1;
    end

    assign expire    = (state_q == S_GRANT) && !i_done && (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign o_timeout = expire && !i_rst;
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_en && any) begin
                    state_d   = S_GRANT;
                    grant_d   = pick;
                    new_grant = 1'b1;
                end
            end
            S_GRANT: begin
                if (i_done || expire) begin
                    ptr_d = rot_ptr;
                    if (i_en && any) begin
                        grant_d   = pick;
                        new_grant = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_grant_idx = grant_idx;
    assign o_busy      = |grant_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Bench for demux_rr_scheduler: directed vector table, hand sequences and random stimulus
// checked against a behavioural owner/pointer model.
module tb_demux_rr_scheduler;

    localparam int unsigned N  = 8;
    localparam int unsigned MH = 4;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         i_rst = 1'b0, i_en = 1'b0, i_done = 1'b0;
    logic [7:0]   i_req = '0;
    logic [7:0]   o_grant;
    logic [2:0]   o_grant_idx;
    logic         o_busy, o_timeout;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux_rr_scheduler #(
        .N        (N),
        .IDX_W    (3),
        .MAX_HOLD (MH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_req       (i_req),
        .i_done      (i_done),
        .o_grant     (o_grant),
        .o_grant_idx (o_grant_idx),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    // Behavioural model: owner index (-1 = nobody), rotation pointer, cycles held
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    bit   m_valid = 1'b0;
    logic last_to;

    function automatic int pick_from(input logic [7:0] req, input int start);
        for (int i = 0; i < N; i++) begin
            if (req[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_expire(input logic rst, input logic done);
        return TO_EN && !rst && (m_owner >= 0) && !done && (m_held == int'(MH) - 1);
    endfunction

    task automatic model_edge(input logic rst, input logic en, input logic [7:0] req, input logic done);
        bit rel;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_valid = 1'b1;
        end else if (m_owner < 0) begin
            if (en && req != 0) begin
                m_owner = pick_from(req, m_ptr); m_held = 0;
            end
        end else begin
            rel = done || model_expire(rst, done);
            if (rel) begin
                m_ptr = (m_owner + 1) % N;
                if (en && req != 0) begin
                    m_owner = pick_from(req, m_ptr); m_held = 0;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [7:0] req, input logic done);
        logic [7:0] eg;
        @(negedge clk);
        i_rst = rst; i_en = en; i_req = req; i_done = done;
        #1;
        last_to = o_timeout;
        if (m_valid) begin
            eg = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
            check("grant", 32'(o_grant), 32'(eg));
            check("grant_idx", 32'(o_grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
            check("busy", 32'(o_busy), 32'(m_owner >= 0));
            check("timeout", 32'(o_timeout), 32'(model_expire(rst, done)));
        end
        @(posedge clk);
        model_edge(rst, en, req, done);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic       done;
        logic [7:0] exp_grant;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl = '{
            '{1'b1, 1'b1, 8'h01, 1'b0, 8'h00},  // reset
            '{1'b0, 1'b1, 8'h01, 1'b0, 8'h01},  // first grant, 1-cycle latency
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h02},  // full rotation, no bubble
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h04},
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h08},
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h10},
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h20},
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h40},
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h80},
            '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h01},  // wrap 7 -> 0
            '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00},  // release to idle, ptr=1
            '{1'b0, 1'b1, 8'h04, 1'b0, 8'h04},
            '{1'b0, 1'b1, 8'h05, 1'b1, 8'h01},  // ptr=3 wraps to requester 0
            '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00},
            '{1'b0, 1'b0, 8'h10, 1'b0, 8'h00},  // disabled: no grant
            '{1'b0, 1'b0, 8'h10, 1'b1, 8'h00},  // done while idle ignored
            '{1'b0, 1'b0, 8'h10, 1'b0, 8'h00},
            '{1'b0, 1'b0, 8'h10, 1'b0, 8'h00},
            '{1'b0, 1'b0, 8'h10, 1'b0, 8'h00},
            '{1'b0, 1'b1, 8'h10, 1'b0, 8'h10},  // enable -> grant next edge
            '{1'b0, 1'b1, 8'h01, 1'b0, 8'h10},  // frozen while held
            '{1'b0, 1'b1, 8'h00, 1'b0, 8'h10},  // owner dropping req ignored
            '{1'b0, 1'b0, 8'hFF, 1'b0, 8'h10},
            '{1'b0, 1'b0, 8'hFF, 1'b1, 8'h00},  // en=0: no regrant
            '{1'b0, 1'b1, 8'h08, 1'b0, 8'h08},
            '{1'b1, 1'b1, 8'h08, 1'b0, 8'h00},  // reset mid-grant
            '{1'b0, 1'b1, 8'h81, 1'b0, 8'h01},  // ptr back to 0
            '{1'b0, 1'b1, 8'h01, 1'b1, 8'h01},  // lone previous owner wins again
            '{1'b0, 1'b1, 8'h03, 1'b1, 8'h02}
        };

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].done);
            check($sformatf("tbl[%0d].grant", i), 32'(o_grant), 32'(tbl[i].exp_grant));
        end

`ifdef DEMUX_SCHED_TIMEOUT_EN
        // Watchdog: hold for MH cycles, pulse once, regrant the same lone requester
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h02, 1'b0);
        check("to_first_grant", 32'(o_grant), 32'h02);
        for (int c = 0; c < int'(MH); c++) begin
            step(1'b0, 1'b1, 8'h02, 1'b0);
            check($sformatf("to_pulse[%0d]", c), 32'(last_to), 32'(c == int'(MH) - 1));
            check($sformatf("to_hold[%0d]", c), 32'(o_grant), 32'h02);
        end
        // done in the expiry cycle is a normal release
        for (int c = 0; c < int'(MH) - 1; c++) step(1'b0, 1'b1, 8'h02, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("to_done_no_pulse", 32'(last_to), 32'h0);
        check("to_done_release", 32'(o_grant), 32'h00);
`else
        // Without the watchdog a grant is held indefinitely
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h02, 1'b0);
        for (int c = 0; c < 40; c++) step(1'b0, 1'b1, 8'hFF, 1'b0);
        check("hold_forever", 32'(o_grant), 32'h02);
        check("no_timeout", 32'(last_to), 32'h0);
`endif

        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < 85) ? 1'b1 : 1'b0,
                 ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom),
                 ($urandom_range(99) < 30) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
